// File: rtl/pmp_csr.sv
// Machine-mode PMP CSR file: pmpcfg0-3 / pmpaddr0-15 storage with WARL and lock rules.
// Optional build macro PMP_NA4_EN keeps A=NA4 as written; without it NA4 is stored as OFF.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PADDR_LEN
`define PADDR_LEN 34
`endif

module pmp_csr #(
    parameter int XLEN      = `XLEN,
    parameter int PADDR_LEN = `PADDR_LEN,
    parameter int PMP_NUM   = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    csr_en,
    input  logic                    csr_wr,
    input  logic [1:0]              csr_op,
    input  logic [11:0]             csr_addr,
    input  logic [XLEN-1:0]         csr_wdata,
    output logic                    csr_hit,
    output logic [XLEN-1:0]         csr_rdata,
    output logic [PMP_NUM*8-1:0]    pmpcfg,
    output logic [PMP_NUM*XLEN-1:0] pmpaddr,
    output logic                    pmp_upd
);

    // Entries per pmpcfg register, and how many CSR numbers one such register spans.
    localparam int CPB       = XLEN / 8;
    localparam int CSR_SPAN  = CPB / 4;
    localparam int AW        = (PADDR_LEN - 2 < XLEN) ? PADDR_LEN - 2 : XLEN;

    localparam logic [1:0] A_TOR = 2'b01;
    localparam logic [1:0] A_NA4 = 2'b10;
    localparam logic [1:0] A_OFF = 2'b00;

    logic [7:0]      cfg_q   [PMP_NUM];
    logic [7:0]      cfg_d   [PMP_NUM];
    logic [AW-1:0]   addr_q  [PMP_NUM];
    logic [AW-1:0]   addr_d  [PMP_NUM];
    logic [PMP_NUM-1:0] tor_above;
    logic [PMP_NUM-1:0] addr_locked;

    logic [3:0]      idx;
    logic            is_cfg;
    logic            is_addr;
    logic            cfg_hit;
    logic            addr_hit;
    logic            commit;
    logic            changed;
    logic [XLEN-1:0] wr_val;
    logic [7:0]      nb;

    assign idx      = csr_addr[3:0];
    assign is_cfg   = (csr_addr[11:4] == 8'h3A);
    assign is_addr  = (csr_addr[11:4] == 8'h3B);
    assign cfg_hit  = is_cfg && (idx[3:2] == 2'b00) && ((XLEN == 32) || !idx[0]);
    assign addr_hit = is_addr;
    assign csr_hit  = cfg_hit | addr_hit;

    // CSR access protocol: a single-cycle request with no backpressure. csr_rdata reflects the
    // pre-write value combinationally; a write commits at the edge ending the cycle csr_en is high.
    assign commit   = csr_en & csr_wr & csr_hit & (csr_op != 2'd3);

    always_comb begin
        csr_rdata = '0;
        for (int e = 0; e < PMP_NUM; e++) begin
            if (cfg_hit && (e / CPB == int'(idx) / CSR_SPAN))
                csr_rdata[8*(e%CPB) +: 8] = cfg_q[e];
            if (addr_hit && (idx == 4'(e)))
                csr_rdata = XLEN'(addr_q[e]);
        end
    end

    always_comb begin
        case (csr_op)
            2'd0:    wr_val = csr_wdata;
            2'd1:    wr_val = csr_rdata | csr_wdata;
            default: wr_val = csr_rdata & ~csr_wdata;
        endcase
    end

    // An address register is frozen by its own lock, or by a locked TOR entry above it
    // (whose range uses this register as its lower bound).
    always_comb begin
        tor_above = '0;
        for (int e = 0; e < PMP_NUM - 1; e++)
            tor_above[e] = cfg_q[e+1][7] && (cfg_q[e+1][4:3] == A_TOR);
        for (int e = 0; e < PMP_NUM; e++)
            addr_locked[e] = cfg_q[e][7] | tor_above[e];
    end

    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        nb     = 8'h00;
        for (int e = 0; e < PMP_NUM; e++) begin
            nb      = wr_val[8*(e%CPB) +: 8];
            nb[6:5] = 2'b00;
`ifndef PMP_NA4_EN
            if (nb[4:3] == A_NA4)
                nb[4:3] = A_OFF;
`endif
            if (commit && cfg_hit && (e / CPB == int'(idx) / CSR_SPAN)
                && !cfg_q[e][7] && !(!nb[0] && nb[1]))
                cfg_d[e] = nb;
            if (commit && addr_hit && (idx == 4'(e)) && !addr_locked[e])
                addr_d[e] = wr_val[AW-1:0];
        end
    end

    always_comb begin
        changed = 1'b0;
        for (int e = 0; e < PMP_NUM; e++)
            if ((cfg_d[e] != cfg_q[e]) || (addr_d[e] != addr_q[e]))
                changed = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < PMP_NUM; e++) begin
                cfg_q[e]  <= 8'h00;
                addr_q[e] <= '0;
            end
            pmp_upd <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            pmp_upd <= changed;
        end
    end

    for (genvar g = 0; g < PMP_NUM; g++) begin : g_out
        assign pmpcfg[8*g +: 8]        = cfg_q[g];
        assign pmpaddr[XLEN*g +: XLEN] = XLEN'(addr_q[g]);
    end

endmodule

// File: tb/tb_pmp_csr.sv
// Self-checking bench for pmp_csr: directed cases then randomized CSR traffic against
// a reference model of the PMP register rules.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PADDR_LEN
`define PADDR_LEN 34
`endif

module tb_pmp_csr;

    localparam int XLEN      = `XLEN;
    localparam int PADDR_LEN = `PADDR_LEN;
    localparam int N         = 16;
    localparam int CPB       = XLEN / 8;
    localparam int AW        = (PADDR_LEN - 2 < XLEN) ? PADDR_LEN - 2 : XLEN;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              csr_en = 1'b0;
    logic              csr_wr = 1'b0;
    logic [1:0]        csr_op = 2'd0;
    logic [11:0]       csr_addr = 12'h000;
    logic [XLEN-1:0]   csr_wdata = '0;
    logic              csr_hit;
    logic [XLEN-1:0]   csr_rdata;
    logic [N*8-1:0]    pmpcfg;
    logic [N*XLEN-1:0] pmpaddr;
    logic              pmp_upd;

    // clock / reset
    always #5 clk = ~clk;

    pmp_csr dut (
        .clk       (clk),
        .rstn      (rstn),
        .csr_en    (csr_en),
        .csr_wr    (csr_wr),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_hit   (csr_hit),
        .csr_rdata (csr_rdata),
        .pmpcfg    (pmpcfg),
        .pmpaddr   (pmpaddr),
        .pmp_upd   (pmp_upd)
    );

    // reference model state and scoreboard
    logic [7:0]      m_cfg  [N];
    logic [XLEN-1:0] m_addr [N];
    logic [XLEN-1:0] amask;
    logic [XLEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [11:0] a);
        if (a >= 12'h3B0 && a <= 12'h3BF) return 1'b1;
        if (a >= 12'h3A0 && a <= 12'h3A3) return (XLEN == 32) || (a[0] == 1'b0);
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [11:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (!m_hit(a)) return v;
        if (a >= 12'h3B0) return m_addr[int'(a) - 'h3B0];
        for (int b = 0; b < CPB; b++)
            v[8*b +: 8] = m_cfg[(int'(a) - 'h3A0) * 4 + b];
        return v;
    endfunction

    // Applies one committed write to the model; returns whether any stored value changed.
    function automatic bit m_write(input logic [1:0] op, input logic [11:0] a, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] old, nv, st;
        logic [7:0] byte_v;
        bit ch;
        int i, e;
        ch = 1'b0;
        old = m_read(a);
        nv = (op == 2'd0) ? d : (op == 2'd1) ? (old | d) : (old & ~d);
        if (a >= 12'h3B0) begin
            i = int'(a) - 'h3B0;
            if (!(m_cfg[i][7] || (i < 15 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'b01))) begin
                st = nv & amask;
                ch = (st != m_addr[i]);
                m_addr[i] = st;
            end
        end else begin
            for (int b = 0; b < CPB; b++) begin
                e = (int'(a) - 'h3A0) * 4 + b;
                byte_v = nv[8*b +: 8] & 8'h9F;
`ifndef PMP_NA4_EN
                if (byte_v[4:3] == 2'b10) byte_v[4:3] = 2'b00;
`endif
                if (!m_cfg[e][7] && byte_v[1:0] != 2'b10) begin
                    if (byte_v != m_cfg[e]) ch = 1'b1;
                    m_cfg[e] = byte_v;
                end
            end
        end
        return ch;
    endfunction

    task automatic check_all(input string tag);
        for (int e = 0; e < N; e++) begin
            check($sformatf("%s_cfg%0d", tag, e), 64'(pmpcfg[8*e +: 8]), 64'(m_cfg[e]));
            check($sformatf("%s_addr%0d", tag, e), 64'(pmpaddr[XLEN*e +: XLEN]), 64'(m_addr[e]));
        end
    endtask

    // driver tasks
    task automatic access(input bit en, input bit wr, input logic [1:0] op,
                          input logic [11:0] a, input logic [XLEN-1:0] d, input string tag);
        bit exp_upd;
        @(negedge clk);
        csr_en = en; csr_wr = wr; csr_op = op; csr_addr = a; csr_wdata = d;
        exp_q.push_back(m_read(a));
        #1;
        check({tag, "_hit"}, 64'(csr_hit), 64'(m_hit(a)));
        check({tag, "_rdata"}, 64'(csr_rdata), 64'(exp_q.pop_front()));
        exp_upd = 1'b0;
        if (en && wr && m_hit(a) && op != 2'd3) exp_upd = m_write(op, a, d);
        @(posedge clk);
        #1;
        csr_en = 1'b0; csr_wr = 1'b0;
        check({tag, "_upd"}, 64'(pmp_upd), 64'(exp_upd));
        check_all(tag);
    endtask

    task automatic do_reset(input bit with_write);
        @(negedge clk);
        rstn = 1'b0;
        csr_en = with_write; csr_wr = with_write; csr_op = 2'd0;
        csr_addr = 12'h3B3; csr_wdata = '1;
        @(posedge clk);
        #1;
        rstn = 1'b1; csr_en = 1'b0; csr_wr = 1'b0;
        for (int e = 0; e < N; e++) begin
            m_cfg[e] = 8'h00;
            m_addr[e] = '0;
        end
        check("rst_upd", 64'(pmp_upd), 64'd0);
        check_all("rst");
    endtask

    logic [11:0]     ra;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] lmask;
    logic [63:0]     r64;
    int              sel;

    initial begin
        amask = (AW >= XLEN) ? '1 : ((XLEN'(1) << AW) - XLEN'(1));
        lmask = '0;
        for (int b = 0; b < CPB; b++) lmask[8*b + 7] = 1'b1;

        do_reset(1'b0);
        access(1, 0, 2'd0, 12'h3A0, '0, "t1_rd_cfg0");
        check("t1_cfg0_zero", 64'(csr_rdata), 64'd0);
        access(1, 0, 2'd0, 12'h3B5, '0, "t1_rd_addr5");

        access(1, 1, 2'd0, 12'h3A0, XLEN'(32'h0000_1F0F), "t2_wr");
        check("t2_b0", 64'(pmpcfg[7:0]), 64'h0F);
        check("t2_b1", 64'(pmpcfg[15:8]), 64'h1F);
        access(1, 1, 2'd0, 12'h3A0, XLEN'(32'h0000_1F0F), "t2_same");

        access(1, 1, 2'd0, 12'h3A0, XLEN'(32'h0000_1F02), "t3_rsvd");
        check("t3_b0_kept", 64'(pmpcfg[7:0]), 64'h0F);
        access(1, 1, 2'd1, 12'h3A0, XLEN'(32'h0000_0080), "t3_setl");
        check("t3_b0_locked", 64'(pmpcfg[7:0]), 64'h8F);
        access(1, 1, 2'd0, 12'h3B0, XLEN'(32'h0000_1234), "t3_addr0");
        check("t3_addr0_kept", 64'(pmpaddr[XLEN-1:0]), 64'd0);

        access(1, 1, 2'd0, 12'h3A0, XLEN'(32'h0000_888F), "t4_tor");
        check("t4_b1", 64'(pmpcfg[15:8]), 64'h88);
        access(1, 1, 2'd0, 12'h3B0, XLEN'(32'h0000_1234), "t4_addr0");
        access(1, 1, 2'd0, 12'h3B1, XLEN'(32'h0000_5678), "t4_addr1");
        check("t4_addr1_kept", 64'(pmpaddr[XLEN*1 +: XLEN]), 64'd0);
        access(1, 1, 2'd0, 12'h3B2, XLEN'(32'h0000_9ABC), "t4_addr2");
        check("t4_addr2_new", 64'(pmpaddr[XLEN*2 +: XLEN]), 64'h9ABC);

        access(1, 1, 2'd1, 12'h3A0, XLEN'(32'h1300_0000), "t5_na4");
`ifdef PMP_NA4_EN
        check("t5_b3", 64'(pmpcfg[31:24]), 64'h13);
`else
        check("t5_b3", 64'(pmpcfg[31:24]), 64'h03);
`endif
        access(1, 1, 2'd3, 12'h3B4, XLEN'(32'h0000_0044), "t5_op3");
        access(0, 1, 2'd0, 12'h3B4, XLEN'(32'h0000_0044), "t5_noen");
        access(1, 1, 2'd0, 12'h3B4, XLEN'(32'h0000_0044), "t5_b2b_a");
        access(1, 1, 2'd0, 12'h3B5, XLEN'(32'h0000_0055), "t5_b2b_b");

        access(1, 1, 2'd0, 12'h3A1, '1, "t6_3a1");
        access(1, 1, 2'd0, 12'h7C0, '1, "t6_miss");
        do_reset(1'b1);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      ra = 12'(32'h3A0 + $urandom_range(0, 3));
            else if (sel < 9) ra = 12'(32'h3B0 + $urandom_range(0, 15));
            else              ra = 12'(32'h300 + $urandom_range(0, 255));
            r64 = {$urandom(), $urandom()};
            rd = r64[XLEN-1:0];
            if ($urandom_range(0, 7) != 0) rd = rd & ~lmask;
            access($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                   2'($urandom_range(0, 3)), ra, rd, $sformatf("rnd%0d", n));
            if (n % 150 == 149) do_reset($urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
